// File: rtl/mem_stage_pkg.sv
// Shared constants and bus layouts for the memory-access pipeline stage.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a; stall semantics are carried by the STOP/NO_STOP encodings.
package mem_stage_pkg;

  localparam int STALL_W      = 6;
  localparam int EX_TO_MEM_WD = 80;
  localparam int MEM_TO_WB_WD = 70;
  localparam int MEM_TO_ID_FW = 38;

  // Stall vector bit values
  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // ld_op encodings, shared with decode and execute
  localparam logic [3:0] LD_NONE = 4'b0000;
  localparam logic [3:0] LD_LW   = 4'b1111;
  localparam logic [3:0] LD_LB   = 4'b0001;
  localparam logic [3:0] LD_LBU  = 4'b0010;
  localparam logic [3:0] LD_LH   = 4'b0011;
  localparam logic [3:0] LD_LHU  = 4'b0100;
  localparam logic [3:0] ST_SB   = 4'b0101;
  localparam logic [3:0] ST_SH   = 4'b0111;

  // EX->MEM bus layout, msb first
  typedef struct packed {
    logic [3:0]  ld_op;
    logic [31:0] pc;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_mem_t;

  // MEM->WB bus layout; the low 38 bits double as the forwarding bus
  typedef struct packed {
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
  } mem_wb_t;

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
    return {{24{sgn & b[7]}}, b};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
    return {{16{sgn & h[15]}}, h};
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Aligns and extends a loaded SRAM word according to ld_op and the byte address.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the result follows its inputs.
module mem_stage_load_align
  import mem_stage_pkg::*;
(
  input  logic [3:0]  ld_op,
  input  logic [1:0]  addr,
  input  logic [31:0] word,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte and halfword; addr[0] is ignored for halfwords
  always_comb begin
    byte_sel = word[7:0];
    case (addr)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    half_sel = addr[1] ? word[31:16] : word[15:0];
  end

  // Extend according to load type; stores and ALU ops see the raw word
  always_comb begin
    result = word;
    case (ld_op)
      LD_LB:  result = ext8(byte_sel, 1'b1);
      LD_LBU: result = ext8(byte_sel, 1'b0);
      LD_LH:  result = ext16(half_sel, 1'b1);
      LD_LHU: result = ext16(half_sel, 1'b0);
      LD_LW, LD_NONE, ST_SB, ST_SH: result = word;
      default: result = word;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: registers EX->MEM, aligns load data, drives MEM->WB and MEM->ID.
// Latency: 1 cycle register, outputs combinational from it (0 cycles after the register).
// Backpressure: stall[3] holds the register (bubble if stall[4] is clear); SRAM word is captured while held.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_W-1:0]      stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [31:0]             data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [MEM_TO_ID_FW-1:0] mem_to_id_bus
);

  ex_mem_t     stage_q;
  logic [31:0] rdata_hold;
  logic        hold_vld;
  logic [31:0] eff_rdata;
  logic [31:0] load_result;
  mem_wb_t     wb;

  logic stop_here;
  logic stop_wb;
  logic do_bubble;
  logic do_load;

  assign stop_here = (stall[3] == STOP);
  assign stop_wb   = (stall[4] == STOP);
  assign do_bubble = stop_here && !stop_wb;
  assign do_load   = !stop_here;

  // Stage register: reset, then bubble, then load, otherwise hold
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
    end else if (do_bubble) begin
      stage_q <= '0;
    end else if (do_load) begin
      stage_q <= ex_to_mem_bus;
    end
  end

  // Capture the SRAM word on the first held cycle so the load survives long stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_vld   <= 1'b0;
      rdata_hold <= '0;
    end else if (do_load || do_bubble) begin
      hold_vld   <= 1'b0;
    end else if (!hold_vld) begin
      rdata_hold <= data_sram_rdata;
      hold_vld   <= 1'b1;
    end
  end

  assign eff_rdata = hold_vld ? rdata_hold : data_sram_rdata;

  mem_stage_load_align u_load_align (
    .ld_op  (stage_q.ld_op),
    .addr   (stage_q.ex_result[1:0]),
    .word   (eff_rdata),
    .result (load_result)
  );

  // Writeback value select; outputs forced to zero while reset is asserted
  always_comb begin
    wb          = '0;
    wb.pc       = stage_q.pc;
    wb.rf_we    = stage_q.rf_we;
    wb.rf_waddr = stage_q.rf_waddr;
    wb.rf_wdata = stage_q.sel_rf_res ? load_result : stage_q.ex_result;
    mem_to_wb_bus = rst ? '0 : wb;
  end

  assign mem_to_id_bus = mem_to_wb_bus[MEM_TO_ID_FW-1:0];

  // SRAM write controls are consumed upstream; other stall bits belong to other stages
  logic unused_bits;
  assign unused_bits = ^{stall[5], stall[2:0], stage_q.ram_en, stage_q.ram_wen};

endmodule
